vga_timing_gen: RTL and testbench
=================================

// Module: vga_timing_gen
// PURPOSE
//  Source end of the vga_if pixel stream: generates hcount/vcount, blanking and sync for the
//  sprite/background draw chain (layers take vga_if.in, emit vga_if.out). Sits at the head of
//  the video pipeline. It drives rgb black so downstream layers composite onto a defined base.
//  It also emits frame/line strobes used by game logic (position, animation, weapon updates).
// PARAMETERS
//  H_PIX      800   visible pixels per line
//  H_FP       40    horizontal front porch, pixels
//  H_SYNC     128   hsync width, pixels
//  H_BP       88    horizontal back porch, pixels (H_TOTAL = sum = 1056)
//  V_PIX      600   visible lines per frame
//  V_FP       1     vertical front porch, lines
//  V_SYNC     4     vsync width, lines
//  V_BP       23    vertical back porch, lines (V_TOTAL = sum = 628)
//  HSYNC_POL  1     active level of hsync (1 = active-high)
//  VSYNC_POL  1     active level of vsync
// PORTS
//  clk          in   1   pixel-rate clock
//  rst          in   1   reset: synchronous, active-high
//  en           in   1   advance enable; counters step only when high
//  vga_out      out  if  vga_if.out: hcount[10:0], vcount[10:0], hsync, vsync, hblnk, vblnk, rgb[11:0]
//  frame_start  out  1   one-cycle pulse on entry to (0,0)
//  line_start   out  1   one-cycle pulse on entry to hcount==0 (any line)
// BEHAVIOUR
//  - All outputs registered. hcount, vcount, blank and sync are mutually aligned:
//    - blank/sync on a cycle describe the hcount/vcount presented on that same cycle.
//    - Flags are computed from next-count values.
//  - Reset:
//    - hcount = 0, vcount = 0, hblnk = 0, vblnk = 0, rgb = 0.
//    - hsync = ~HSYNC_POL, vsync = ~VSYNC_POL.
//    - frame_start = 0, line_start = 0.
//  - Counting, en=1:
//    - hcount = hcount+1.
//    - At H_TOTAL-1, hcount wraps to 0 and vcount = vcount+1.
//    - At (H_TOTAL-1, V_TOTAL-1) both wrap to 0.
//  - en=0: all vga_out fields hold; frame_start and line_start are 0.
//  - hblnk = (hcount >= H_PIX); vblnk = (vcount >= V_PIX).
//  - hsync active iff H_PIX+H_FP <= hcount < H_PIX+H_FP+H_SYNC.
//  - vsync active iff V_PIX+V_FP <= vcount < V_PIX+V_FP+V_SYNC.
//    - vsync switches on the same cycle hcount wraps to 0.
//  - line_start = 1 for exactly the cycle in which the presented hcount becomes 0 via wrap.
//  - frame_start = 1 only when both hcount and vcount become 0 via wrap.
//  - frame_start always coincides with line_start.
//  - Neither strobe is asserted by reset itself; the first frame_start follows one full frame.
//  - rgb is constant 12'h000 at all times.
//  - Counters are unsigned, 11 bits wide; values never exceed H_TOTAL-1 / V_TOTAL-1.
//  - Reset mid-frame: the next cycle presents the reset values; counting resumes from (0,0).
//    - No partial sync pulse is held over.
//  - Latency from en to the first count change: 1 cycle.
// TESTING
//  1. Reset then en=1 constant:
//     - hcount steps 0..1055 then 0.
//     - vcount increments on each wrap.
//     - line_start high at each wrap.
//     - frame_start first high after 1056*628 = 663168 cycles.
//  2. Horizontal timing over one line:
//     - hblnk rises at hcount=800.
//     - hsync active for hcount 840..967 (128 cycles).
//     - hblnk falls at hcount=0.
//  3. Vertical timing over one frame:
//     - vblnk high for vcount 600..627.
//     - vsync active for vcount 601..604.
//     - vsync edges coincide with hcount=0.
//  4. en toggled 1/0 every cycle:
//     - Outputs hold on en=0 cycles.
//     - frame period doubles to 1326336 clk cycles.
//     - No strobe is asserted while en=0.
//  5. rst asserted at (hcount=500, vcount=300) for 1 cycle:
//     - Next cycle shows hcount=0, vcount=0, syncs inactive, no strobes.
//     - Count resumes at 1.
//  6. HSYNC_POL=0, VSYNC_POL=0:
//     - Syncs idle high and pulse low at the same positions as scenarios 2 and 3.
//     - rgb == 0 throughout.

Source files
------------

// File: rtl/vga_timing_gen_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : vga_if                                                         |
// | Brief    : Pixel-stream bundle passed along the video draw chain:         |
// |            counters, blanking, sync and 12-bit colour.                    |
// | Revision : 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
interface vga_if;
   logic [10:0] hcount;
   logic [10:0] vcount;
   logic        hsync;
   logic        vsync;
   logic        hblnk;
   logic        vblnk;
   logic [11:0] rgb;

   modport out (output hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
   modport in  (input  hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
endinterface
`default_nettype wire

// File: rtl/vga_timing_gen.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : vga_timing_gen                                                 |
// | Brief    : Head of the video pipeline. Generates hcount/vcount, blanking, |
// |            sync and a black rgb base, plus frame/line strobes for game    |
// |            logic. All outputs registered and mutually aligned.            |
// | Revision : 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module vga_timing_gen #(
   parameter int H_PIX     = 800,
   parameter int H_FP      = 40,
   parameter int H_SYNC    = 128,
   parameter int H_BP      = 88,
   parameter int V_PIX     = 600,
   parameter int V_FP      = 1,
   parameter int V_SYNC    = 4,
   parameter int V_BP      = 23,
   parameter bit HSYNC_POL = 1'b1,
   parameter bit VSYNC_POL = 1'b1
) (
   input  logic  clk,
   input  logic  rst,
   input  logic  en,
   vga_if.out    vga_out,
   output logic  frame_start,
   output logic  line_start
);

   localparam int          H_TOTAL        = H_PIX + H_FP + H_SYNC + H_BP;
   localparam int          V_TOTAL        = V_PIX + V_FP + V_SYNC + V_BP;
   localparam logic [10:0] c_H_LAST       = 11'(H_TOTAL - 1);
   localparam logic [10:0] c_V_LAST       = 11'(V_TOTAL - 1);
   localparam logic [10:0] c_H_PIX        = 11'(H_PIX);
   localparam logic [10:0] c_V_PIX        = 11'(V_PIX);
   localparam logic [10:0] c_HSYNC_START  = 11'(H_PIX + H_FP);
   localparam logic [10:0] c_HSYNC_END    = 11'(H_PIX + H_FP + H_SYNC);
   localparam logic [10:0] c_VSYNC_START  = 11'(V_PIX + V_FP);
   localparam logic [10:0] c_VSYNC_END    = 11'(V_PIX + V_FP + V_SYNC);

   logic [10:0] r_hcount;
   logic [10:0] r_vcount;
   logic        r_hsync;
   logic        r_vsync;
   logic        r_hblnk;
   logic        r_vblnk;
   logic        r_frame_start;
   logic        r_line_start;

   logic        w_h_wrap;
   logic        w_v_wrap;
   logic [10:0] w_hcount_nxt;
   logic [10:0] w_vcount_nxt;
   logic        w_hsync_act;
   logic        w_vsync_act;

   // Next-count values; blank/sync are derived from these so they line up
   // with the counts they will be presented alongside.
   always_comb begin
      w_h_wrap     = (r_hcount == c_H_LAST);
      w_v_wrap     = (r_vcount == c_V_LAST);
      w_hcount_nxt = w_h_wrap ? 11'd0 : r_hcount + 11'd1;
      w_vcount_nxt = r_vcount;
      if (w_h_wrap) begin
         w_vcount_nxt = w_v_wrap ? 11'd0 : r_vcount + 11'd1;
      end
      w_hsync_act  = (w_hcount_nxt >= c_HSYNC_START) && (w_hcount_nxt < c_HSYNC_END);
      w_vsync_act  = (w_vcount_nxt >= c_VSYNC_START) && (w_vcount_nxt < c_VSYNC_END);
   end

   // Counter/flag registers: advance on en, hold otherwise; strobes only on advance.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_hcount      <= 11'd0;
         r_vcount      <= 11'd0;
         r_hblnk       <= 1'b0;
         r_vblnk       <= 1'b0;
         r_hsync       <= ~HSYNC_POL;
         r_vsync       <= ~VSYNC_POL;
         r_frame_start <= 1'b0;
         r_line_start  <= 1'b0;
      end else if (en) begin
         r_hcount      <= w_hcount_nxt;
         r_vcount      <= w_vcount_nxt;
         r_hblnk       <= (w_hcount_nxt >= c_H_PIX);
         r_vblnk       <= (w_vcount_nxt >= c_V_PIX);
         r_hsync       <= w_hsync_act ? HSYNC_POL : ~HSYNC_POL;
         r_vsync       <= w_vsync_act ? VSYNC_POL : ~VSYNC_POL;
         r_line_start  <= w_h_wrap;
         r_frame_start <= w_h_wrap && w_v_wrap;
      end else begin
         r_frame_start <= 1'b0;
         r_line_start  <= 1'b0;
      end
   end

   assign vga_out.hcount = r_hcount;
   assign vga_out.vcount = r_vcount;
   assign vga_out.hsync  = r_hsync;
   assign vga_out.vsync  = r_vsync;
   assign vga_out.hblnk  = r_hblnk;
   assign vga_out.vblnk  = r_vblnk;
   // Black base for the layers downstream to composite onto.
   assign vga_out.rgb    = 12'h000;
   assign frame_start    = r_frame_start;
   assign line_start     = r_line_start;

endmodule
`default_nettype wire

// File: tb/tb_vga_timing_gen.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_vga_timing_gen                                              |
// | Brief    : Scoreboard bench for vga_timing_gen using a reduced timing set |
// |            and both sync polarities, driven from one stimulus stream.     |
// | Revision : 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module tb_vga_timing_gen;

   localparam int HP  = 16;
   localparam int HFP = 4;
   localparam int HS  = 8;
   localparam int HBP = 4;
   localparam int VP  = 12;
   localparam int VFP = 1;
   localparam int VS  = 3;
   localparam int VBP = 2;
   localparam int HT  = HP + HFP + HS + HBP;   // 32
   localparam int VT  = VP + VFP + VS + VBP;   // 18
   localparam int FRAME = HT * VT;             // 576

   typedef struct packed {
      logic [10:0] hc;
      logic [10:0] vc;
      logic        hs;   // 1 = sync active
      logic        vs;
      logic        hb;
      logic        vb;
      logic        fs;
      logic        ls;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic en  = 1'b0;
   logic fs_a, ls_a, fs_b, ls_b;

   vga_if vif_a();
   vga_if vif_b();

   int   n_checks = 0;
   int   n_errors = 0;
   exp_t sb_q[$];
   int   mh = 0;
   int   mv = 0;

   always #5 clk = ~clk;

   vga_timing_gen #(
      .H_PIX(HP), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
      .V_PIX(VP), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
      .HSYNC_POL(1'b1), .VSYNC_POL(1'b1)
   ) dut_a (
      .clk(clk), .rst(rst), .en(en), .vga_out(vif_a),
      .frame_start(fs_a), .line_start(ls_a)
   );

   vga_timing_gen #(
      .H_PIX(HP), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
      .V_PIX(VP), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
      .HSYNC_POL(1'b0), .VSYNC_POL(1'b0)
   ) dut_b (
      .clk(clk), .rst(rst), .en(en), .vga_out(vif_b),
      .frame_start(fs_b), .line_start(ls_b)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // Expected presentation for counts (h,v), written directly from the timing table.
   function automatic exp_t model_out(input int h, input int v, input bit ls, input bit fs);
      exp_t x;
      x.hc = 11'(h);
      x.vc = 11'(v);
      x.hb = (h >= HP);
      x.vb = (v >= VP);
      x.hs = (h >= HP + HFP) && (h < HP + HFP + HS);
      x.vs = (v >= VP + VFP) && (v < VP + VFP + VS);
      x.ls = ls;
      x.fs = fs;
      return x;
   endfunction

   // One clock: drive inputs, push model expectation, then compare both DUTs.
   task automatic step(input bit r, input bit e);
      exp_t x;
      bit   ls, fs;
      rst = r;
      en  = e;
      ls  = 1'b0;
      fs  = 1'b0;
      if (r) begin
         mh = 0;
         mv = 0;
      end else if (e) begin
         ls = (mh == HT - 1);
         fs = ls && (mv == VT - 1);
         if (mh == HT - 1) begin
            mh = 0;
            mv = (mv == VT - 1) ? 0 : mv + 1;
         end else begin
            mh = mh + 1;
         end
      end
      sb_q.push_back(model_out(mh, mv, ls, fs));
      @(posedge clk);
      #1;
      x = sb_q.pop_front();
      check("a_hcount", 32'(vif_a.hcount), 32'(x.hc));
      check("a_vcount", 32'(vif_a.vcount), 32'(x.vc));
      check("a_hsync",  32'(vif_a.hsync),  32'(x.hs));
      check("a_vsync",  32'(vif_a.vsync),  32'(x.vs));
      check("a_hblnk",  32'(vif_a.hblnk),  32'(x.hb));
      check("a_vblnk",  32'(vif_a.vblnk),  32'(x.vb));
      check("a_rgb",    32'(vif_a.rgb),    32'd0);
      check("a_line_start",  32'(ls_a), 32'(x.ls));
      check("a_frame_start", 32'(fs_a), 32'(x.fs));
      check("b_hcount", 32'(vif_b.hcount), 32'(x.hc));
      check("b_vcount", 32'(vif_b.vcount), 32'(x.vc));
      check("b_hsync",  32'(vif_b.hsync),  32'(!x.hs));
      check("b_vsync",  32'(vif_b.vsync),  32'(!x.vs));
      check("b_hblnk",  32'(vif_b.hblnk),  32'(x.hb));
      check("b_vblnk",  32'(vif_b.vblnk),  32'(x.vb));
      check("b_rgb",    32'(vif_b.rgb),    32'd0);
      check("b_line_start",  32'(ls_b), 32'(x.ls));
      check("b_frame_start", 32'(fs_b), 32'(x.fs));
   endtask

   // Hard stop so the bench can never hang.
   initial begin
      #500000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   // Stimulus sequence.
   initial begin
      int first_fs;
      int hs_cnt, vs_cnt, ls_cnt;
      int t1, t2, strobe_en0;
      int guard;
      bit hit;
      #1;
      // Reset state
      step(1'b1, 1'b0);
      step(1'b1, 1'b1);

      // Free-running for two frames
      first_fs = -1;
      hs_cnt = 0;
      vs_cnt = 0;
      ls_cnt = 0;
      for (int i = 0; i < 2 * FRAME; i++) begin
         step(1'b0, 1'b1);
         if (fs_a && first_fs < 0) first_fs = i + 1;
         if (i < FRAME) begin
            if (vif_a.hsync) hs_cnt++;
            if (vif_a.vsync) vs_cnt++;
         end
         if (ls_a) ls_cnt++;
      end
      check("first_frame_start", 32'(first_fs), 32'(FRAME));
      check("hsync_cycles_per_frame", 32'(hs_cnt), 32'(HS * VT));
      check("vsync_cycles_per_frame", 32'(vs_cnt), 32'(VS * HT));
      check("line_starts_two_frames", 32'(ls_cnt), 32'(2 * VT));

      // en toggling every cycle: frame period doubles, no strobes on en=0
      t1 = -1;
      t2 = -1;
      strobe_en0 = 0;
      for (int i = 0; i < 4 * FRAME + 8; i++) begin
         step(1'b0, (i % 2) == 0);
         if ((i % 2) == 1 && (fs_a || ls_a || fs_b || ls_b)) strobe_en0++;
         if (fs_a) begin
            if (t1 < 0) t1 = i;
            else if (t2 < 0) t2 = i;
         end
         if (t2 >= 0) break;
      end
      check("toggle_frame_period", 32'(t2 - t1), 32'(2 * FRAME));
      check("strobe_while_en0", 32'(strobe_en0), 32'd0);

      // Reset in the middle of an hsync+vsync pulse
      hit = 1'b0;
      guard = 0;
      while (!hit && guard < 2 * FRAME) begin
         step(1'b0, 1'b1);
         guard++;
         hit = (vif_a.hcount == 11'd22) && (vif_a.vcount == 11'd14);
      end
      check("reached_reset_point", 32'(hit), 32'd1);
      step(1'b1, 1'b1);
      check("mid_reset_hsync_idle", 32'(vif_a.hsync), 32'd0);
      check("mid_reset_vsync_idle_b", 32'(vif_b.vsync), 32'd1);
      step(1'b0, 1'b1);
      check("resume_hcount", 32'(vif_a.hcount), 32'd1);
      for (int i = 0; i < HT + 4; i++) step(1'b0, 1'b1);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire
